// File: rtl/display_pkg.sv
// Shared types and constants for the time display driver: conversion FSM states
// and the active-low seven-segment decode table.
package display_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } conv_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // {g,f,e,d,c,b,a}, active-low; codes above 9 stay dark
    localparam logic [6:0] SEG_LUT [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F
    };

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per cycle, result committed in one step
// so bcd never shows a partially converted value.
module bin2bcd_seq
    import display_pkg::*;
#(
    parameter int IN_W   = 24,
    parameter int DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [IN_W-1:0]       bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);
    localparam int CNT_W = $clog2(IN_W);

    conv_state_t           state_q, state_d;
    logic [IN_W-1:0]       bin_q, bin_d;
    logic [4*DIGITS-1:0]   scr_q, scr_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [4*DIGITS-1:0]   adj;

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        scr_d   = scr_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        adj     = scr_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scr_q[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d   = bin;
                    scr_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                {scr_d, bin_d} = {adj[4*DIGITS-2:0], bin_q, 1'b0};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(IN_W - 1))
                    state_d = COMMIT;
            end
            COMMIT: begin
                bcd_d   = scr_q;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bin_q   <= '0;
            scr_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            scr_q   <= scr_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: rtl/time_display_driver.sv
// Binary clock value -> BCD -> multiplexed 8-digit seven-segment display.
// Conversion and digit scanning run independently of each other.
module time_display_driver
    import display_pkg::*;
#(
    parameter int          SCAN_TICKS  = 100_000,
    parameter int          BLANK_UPPER = 1,
    parameter logic [7:0]  DP_MASK     = 8'h14
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] number,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [31:0] bcd,
    output logic        conv_busy
);
    localparam int TICK_W = $clog2(SCAN_TICKS);

    logic [23:0]       last_q, last_d;
    logic [31:0]       bcd_q, bcd_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [2:0]        idx_q, idx_d;
    logic [7:0]        an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;
    logic              start, wrap;
    logic              busy, done;
    logic [31:0]       conv_bcd;
    logic [3:0]        nib;

    bin2bcd_seq #(.IN_W(24), .DIGITS(8)) u_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bin   (number),
        .busy  (busy),
        .done  (done),
        .bcd   (conv_bcd)
    );

    always_comb begin
        // only start when the converter can accept, so last_q tracks what was really captured
        start  = (number != last_q) && !busy;
        last_d = start ? number : last_q;
        bcd_d  = done ? conv_bcd : bcd_q;

        wrap   = (tick_q == TICK_W'(SCAN_TICKS - 1));
        tick_d = wrap ? '0 : tick_q + 1'b1;
        idx_d  = wrap ? idx_q + 3'd1 : idx_q;

        nib    = bcd_q[4*idx_q +: 4];
        an_d   = ~(8'b1 << idx_q);
        seg_d  = SEG_LUT[nib];
        dp_d   = ~DP_MASK[idx_q];
        if (BLANK_UPPER != 0 && idx_q >= 3'd6) begin
            seg_d = SEG_BLANK;
            dp_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= '0;
            bcd_q  <= '0;
            tick_q <= '0;
            idx_q  <= '0;
            an_q   <= 8'hFF;
            seg_q  <= SEG_BLANK;
            dp_q   <= 1'b1;
        end else begin
            last_q <= last_d;
            bcd_q  <= bcd_d;
            tick_q <= tick_d;
            idx_q  <= idx_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
        end
    end

    assign an        = an_q;
    assign seg       = seg_q;
    assign dp        = dp_q;
    assign bcd       = bcd_q;
    assign conv_busy = busy;

endmodule

// File: tb/tb_time_display_driver.sv
// Directed + random bench for time_display_driver with a decimal-arithmetic reference model.
module tb_time_display_driver;

    localparam int SCAN = 4;

    logic        clk;
    logic        rst_n;
    logic [23:0] number;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [31:0] bcd;
    logic        conv_busy;

    int checks = 0;
    int errors = 0;
    int cyc;

    logic [6:0] seg_ref [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                  7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    logic [7:0] dp_mask = 8'h14;

    time_display_driver #(.SCAN_TICKS(SCAN), .BLANK_UPPER(1), .DP_MASK(8'h14)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .number    (number),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .bcd       (bcd),
        .conv_busy (conv_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // posedges since the last reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r;
        int          x;
        r = '0;
        x = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // digit k is lit for SCAN cycles, starting with digit 0 on the first edge after release
    task automatic chk_scan(input bit with_seg, input int val);
        int          idx;
        logic [31:0] d;
        logic [6:0]  s;
        idx = ((cyc - 1) / SCAN) % 8;
        d   = to_bcd(val);
        chk("an", {24'h0, an}, {24'h0, ~(8'h01 << idx)});
        chk("dp", {31'h0, dp}, (idx >= 6) ? 32'd1 : {31'h0, ~dp_mask[idx]});
        if (with_seg) begin
            s = (idx >= 6) ? 7'h7F : seg_ref[d[4*idx +: 4]];
            chk("seg", {25'h0, seg}, {25'h0, s});
        end
    endtask

    // number already changed before the next posedge, which is the capture edge
    task automatic watch(input int v, input int old);
        for (int k = 0; k <= 26; k++) begin
            @(negedge clk);
            chk("conv_busy", {31'h0, conv_busy}, (k <= 24) ? 32'd1 : 32'd0);
            chk_scan(1'b0, 0);
            if (k == 25) chk("bcd_hold", bcd, to_bcd(old));
            if (k == 26) chk("bcd_result", bcd, to_bcd(v));
        end
    endtask

    task automatic run_conv(input int v, input int old);
        number = 24'(v);
        watch(v, old);
    endtask

    initial begin
        int cur;
        int v;

        // 1: reset holds everything at rest
        rst_n  = 1'b0;
        number = 24'd123456;
        repeat (3) begin
            @(negedge clk);
            chk("rst_an", {24'h0, an}, 32'hFF);
            chk("rst_seg", {25'h0, seg}, 32'h7F);
            chk("rst_dp", {31'h0, dp}, 32'd1);
            chk("rst_bcd", bcd, 32'h0);
            chk("rst_busy", {31'h0, conv_busy}, 32'd0);
        end

        // 2: first conversion after release
        rst_n = 1'b1;
        watch(123456, 0);

        // 3: extremes of the input range
        run_conv(24'hFFFFFF, 123456);
        chk("bcd_max", bcd, 32'h16777215);
        run_conv(0, 24'hFFFFFF);

        // 4: input changes mid-conversion
        number = 24'd235959;
        for (int k = 0; k <= 52; k++) begin
            @(negedge clk);
            if (k == 25) chk("mid_busy_gap", {31'h0, conv_busy}, 32'd0);
            if (k == 26) begin
                chk("mid_first", bcd, 32'h00235959);
                chk("mid_recapture", {31'h0, conv_busy}, 32'd1);
            end
            if (k == 51) chk("mid_hold", bcd, 32'h00235959);
            if (k == 52) chk("mid_second", bcd, 32'h00000001);
            if (k == 9) number = 24'd1;
        end

        // 5: full scan sweep with a stable value
        run_conv(235959, 1);
        repeat (40) begin
            @(negedge clk);
            chk_scan(1'b1, 235959);
        end
        cur = 235959;

        // random values against the decimal model
        repeat (6) begin
            v = int'($urandom_range(0, 24'hFFFFFF));
            if (v == cur) v = v ^ 1;
            run_conv(v, cur);
            cur = v;
            repeat (12) begin
                @(negedge clk);
                chk_scan(1'b1, cur);
            end
        end

        // 6: reset in the middle of a conversion
        v = (cur == 654321) ? 654320 : 654321;
        number = 24'(v);
        repeat (13) @(negedge clk);
        chk("pre_rst_busy", {31'h0, conv_busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_an", {24'h0, an}, 32'hFF);
        chk("arst_seg", {25'h0, seg}, 32'h7F);
        chk("arst_dp", {31'h0, dp}, 32'd1);
        chk("arst_bcd", bcd, 32'h0);
        chk("arst_busy", {31'h0, conv_busy}, 32'd0);
        number = 24'd42;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        watch(42, 0);
        chk("bcd_42", bcd, 32'h00000042);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
